uart_rx_param: RTL

Parametrised UART receiver, next generation of the UART RX subsystem. Features:
- Configurable data width and prescale width.
- Run-time selectable parity and 1 or 2 stop bits.
- Two-flop input synchroniser.
- 3-sample majority-vote bit recovery.
- Separate parity and stop error outputs.

It sits between the RX pad and the register/FIFO layer and delivers one parallel word per frame.

---
 rtl/uart_rx_param.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote, optional parity, 1/2 stop bits.
// Optional Break_Det output is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_param #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2_EN,
  input  logic [PRESC_W-1:0] Prescale,
  output logic               Data_Valid,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               Par_Err,
  output logic               Stp_Err
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic               Break_Det
`endif
);

  localparam int BC_W = 4;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  // Handshake: none; Data_Valid/Par_Err/Stp_Err are single-cycle pulses, P_DATA is valid while Data_Valid=1 and held after.
  state_t state_q, state_d;
  logic [1:0]         sync_q;
  logic               rx_s;
  logic               armed_q, armed_d;
  logic [PRESC_W-1:0] p_q, p_d;
  logic               par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BC_W-1:0]    bit_q, bit_d;
  logic               s0_q, s0_d, s1_q, s1_d, vote_q, vote_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_bad_q, par_bad_d, stp_bad_q, stp_bad_d, allz_q, allz_d;
  logic               dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic [DATA_W-1:0]  pdata_q, pdata_d;

  logic [PRESC_W-1:0] presc_c, mid;
  logic               at_lo, at_mid, at_hi, at_end, vote_now, vote, start_det, take_start;

  assign rx_s      = sync_q[1];
  assign presc_c   = (Prescale < PRESC_W'(4)) ? PRESC_W'(4) : Prescale;
  assign mid       = p_q >> 1;
  assign at_lo     = (edge_q == mid - PRESC_W'(1));
  assign at_mid    = (edge_q == mid);
  assign at_hi     = (edge_q == mid + PRESC_W'(1));
  assign at_end    = (edge_q == p_q - PRESC_W'(1));
  assign vote_now  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  // With P=4 the third sample and the bit end coincide, so use the live vote then.
  assign vote      = at_hi ? vote_now : vote_q;
  assign start_det = armed_q & ~rx_s;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    p_d        = p_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    stop2_d    = stop2_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    stp_bad_d  = stp_bad_q;
    allz_d     = allz_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    pdata_d    = pdata_q;
    take_start = 1'b0;

    if (state_q != IDLE && state_q != DONE) begin
      edge_d = at_end ? '0 : edge_q + PRESC_W'(1);
      if (at_lo)  s0_d   = rx_s;
      if (at_mid) s1_d   = rx_s;
      if (at_hi)  vote_d = vote_now;
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        if (rx_s) armed_d = 1'b1;
        take_start = start_det;
      end
      START: begin
        if (at_end) begin
          bit_d   = '0;
          state_d = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_hi) begin
          shift_d = {vote_now, shift_q[DATA_W-1:1]};
          allz_d  = allz_q & ~vote_now;
        end
        if (at_end) begin
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end
      PARITY: begin
        if (at_hi) begin
          if (vote_now != (^shift_q ^ par_typ_q)) par_bad_d = 1'b1;
          allz_d = allz_q & ~vote_now;
        end
        if (at_end) begin
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (at_end) bit_d = bit_q + BC_W'(1);
        // Finish on the final stop vote rather than the bit end, leaving slack to resync.
        if (at_hi) begin
          if (!vote_now) stp_bad_d = 1'b1;
          allz_d = allz_q & ~vote_now;
          if (bit_q == {{(BC_W-1){1'b0}}, stop2_q}) begin
            state_d = DONE;
            edge_d  = '0;
            armed_d = vote_now;
          end
        end
      end
      DONE: begin
        edge_d  = '0;
        state_d = IDLE;
        if (rx_s) armed_d = 1'b1;
        dv_d = ~par_bad_q & ~stp_bad_q;
        pe_d = par_bad_q;
        se_d = stp_bad_q;
        if (!par_bad_q && !stp_bad_q) pdata_d = shift_q;
        take_start = start_det;
      end
      default: state_d = IDLE;
    endcase

    if (take_start) begin
      state_d   = START;
      edge_d    = PRESC_W'(1);
      bit_d     = '0;
      p_d       = presc_c;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2_EN;
      par_bad_d = 1'b0;
      stp_bad_d = 1'b0;
      allz_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      armed_q   <= 1'b0;
      p_q       <= PRESC_W'(4);
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      edge_q    <= '0;
      bit_q     <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      vote_q    <= 1'b1;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      allz_q    <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      pdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], RX_IN};
      armed_q   <= armed_d;
      p_q       <= p_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      vote_q    <= vote_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      allz_q    <= allz_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      pdata_q   <= pdata_d;
    end
  end

  assign Data_Valid = dv_q;
  assign P_DATA     = pdata_q;
  assign Par_Err    = pe_q;
  assign Stp_Err    = se_q;

`ifdef UART_RX_BREAK_DET_EN
  logic brk_q, brk_d;

  assign brk_d = (state_q == DONE) & stp_bad_q & allz_q;

  always_ff @(posedge CLK) begin
    if (RST) brk_q <= 1'b0;
    else     brk_q <= brk_d;
  end

  assign Break_Det = brk_q;
`endif

endmodule
